pipe_stage_skid: RTL and testbench

- Generic, parametrised pipeline-stage register for the MIPS core. It supersedes the hand-written per-stage registers that use stall/flush (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload of control and data fields, using a valid/ready handshake with an optional 1-entry skid buffer.
- Stalls become back-pressure, and flush becomes a synchronous kill.
- Also reports occupancy and keeps a saturating count of killed instructions for the performance counters.

---
 rtl/pipe_stage_skid_pkg.sv | 67 ++++++
 rtl/pipe_stage_skid.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline-stage register and its per-stage wrappers.
// Holds the stage state encoding, the default kill-counter width and the ID/EX payload layout.
// Wrappers pack the payload into idex_t and hand it to the stage as an opaque bus.
package pipe_pkg;

  // Stage occupancy states; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

  // ID/EX payload field widths.
  localparam int IDEX_CTRL_W   = 12;
  localparam int IDEX_RDATA_W  = 32;
  localparam int IDEX_IMME_W   = 32;
  localparam int IDEX_FUNC_W   = 6;
  localparam int IDEX_SHAMT_W  = 5;
  localparam int IDEX_OPCODE_W = 6;
  localparam int IDEX_PC_W     = 32;
  localparam int IDEX_REG_W    = 5;
  localparam int IDEX_GT_W     = 1;

  // ID/EX payload field offsets (LSB positions), matching the idex_t packing order.
  localparam int IDEX_GT_LSB      = 0;
  localparam int IDEX_RT_LSB      = IDEX_GT_LSB      + IDEX_GT_W;
  localparam int IDEX_RS_LSB      = IDEX_RT_LSB      + IDEX_REG_W;
  localparam int IDEX_WREG_LSB    = IDEX_RS_LSB      + IDEX_REG_W;
  localparam int IDEX_PC_LSB      = IDEX_WREG_LSB    + IDEX_REG_W;
  localparam int IDEX_OPCODE_LSB  = IDEX_PC_LSB      + IDEX_PC_W;
  localparam int IDEX_SHAMT_LSB   = IDEX_OPCODE_LSB  + IDEX_OPCODE_W;
  localparam int IDEX_FUNC_LSB    = IDEX_SHAMT_LSB   + IDEX_SHAMT_W;
  localparam int IDEX_IMME_LSB    = IDEX_FUNC_LSB    + IDEX_FUNC_W;
  localparam int IDEX_RDATA_B_LSB = IDEX_IMME_LSB    + IDEX_IMME_W;
  localparam int IDEX_RDATA_A_LSB = IDEX_RDATA_B_LSB + IDEX_RDATA_W;
  localparam int IDEX_CTRL_LSB    = IDEX_RDATA_A_LSB + IDEX_RDATA_W;
  localparam int IDEX_W           = IDEX_CTRL_LSB    + IDEX_CTRL_W;

  // ID/EX payload, MSB first; field order must agree with the offsets above.
  typedef struct packed {
    logic [IDEX_CTRL_W-1:0]   ctrl;
    logic [IDEX_RDATA_W-1:0]  rdata_a;
    logic [IDEX_RDATA_W-1:0]  rdata_b;
    logic [IDEX_IMME_W-1:0]   imme;
    logic [IDEX_FUNC_W-1:0]   func;
    logic [IDEX_SHAMT_W-1:0]  shamt;
    logic [IDEX_OPCODE_W-1:0] opcode;
    logic [IDEX_PC_W-1:0]     pc;
    logic [IDEX_REG_W-1:0]    wreg;
    logic [IDEX_REG_W-1:0]    rs;
    logic [IDEX_REG_W-1:0]    rt;
    logic [IDEX_GT_W-1:0]     greater_than;
  } idex_t;

  // Flatten an ID/EX payload onto the stage's opaque data bus.
  function automatic logic [IDEX_W-1:0] idex_pack(input idex_t p);
    return p;
  endfunction

  // Recover the ID/EX fields from the stage's opaque data bus.
  function automatic idex_t idex_unpack(input logic [IDEX_W-1:0] d);
    return idex_t'(d);
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 1-entry skid and flush-as-kill.
// Latency: 1 cycle from accept to out_valid; 1 item/cycle sustained with out_ready held high.
// Backpressure: SKID=1 absorbs one extra item, in_ready registered; SKID=0 in_ready = !main_valid | out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                SKID      = 1,
  parameter int                CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  kill_cnt
);

  localparam int SUM_W = CNT_W + 1;

  state_t            st;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              main_valid;
  logic              skid_valid;
  logic              acc;
  logic              fire;
  logic [1:0]        kill_inc;
  logic [SUM_W-1:0]  kill_sum;

  // Valid flags fall straight out of the state encoding.
  assign main_valid = (st != ST_EMPTY);
  assign skid_valid = (st == ST_SKID);

  // With a skid entry in_ready depends only on state; without one it must look at out_ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign in_ready = ~main_valid | out_ready;
    end
  endgenerate

  assign acc       = in_valid & in_ready;
  assign fire      = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = st;

  // Entries lost to a flush: main unless it leaves this cycle, plus any skid entry.
  assign kill_inc = {1'b0, main_valid & ~out_ready} + {1'b0, skid_valid};
  assign kill_sum = {1'b0, kill_cnt} + SUM_W'(kill_inc);

  // Occupancy FSM; flush overrides every transfer and empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_EMPTY;
    end else if (flush) begin
      st <= ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY: if (acc) st <= ST_FULL;
        ST_FULL: begin
          if (fire && !acc) st <= ST_EMPTY;
          else if (acc && !fire && (SKID != 0)) st <= ST_SKID;
        end
        ST_SKID:  if (fire) st <= ST_FULL;
        default:  st <= ST_EMPTY;
      endcase
    end
  end

  // Payload registers move only on accept/promote so idle bits stay frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (flush) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      case (st)
        ST_EMPTY: if (acc) main_data <= in_data;
        ST_FULL: begin
          if (acc && fire) main_data <= in_data;
          else if (acc && (SKID != 0)) skid_data <= in_data;
        end
        ST_SKID:  if (fire) main_data <= skid_data;
        default:  ;
      endcase
    end
  end

  // Saturating count of entries discarded by flush; the carry bit flags overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_cnt <= '0;
    end else if (flush) begin
      if (kill_sum[CNT_W]) kill_cnt <= '1;
      else                 kill_cnt <= kill_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance (SKID=1, CNT_W=2) and a no-skid instance.
// Accepted inputs are queued; monitors pop and compare on every output transfer.
// Directed checks cover reset state, occupancy, in_ready, flush and counter saturation.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Skid instance signals
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic [1:0] a_kill;

  // No-skid instance signals
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_kill;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  pipe_stage_skid #(.DATA_W(8), .RESET_VAL(8'hE5), .SKID(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .kill_cnt(a_kill)
  );

  pipe_stage_skid #(.DATA_W(8), .RESET_VAL(8'h00), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .kill_cnt(b_kill)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record every accepted input as the next expected output.
  always @(negedge clk) begin
    if (!rst && a_in_valid && a_in_ready && !a_flush) qa.push_back(a_in_data);
    if (!rst && b_in_valid && b_in_ready && !b_flush) qb.push_back(b_in_data);
  end

  // Skid instance monitor: compare each delivered item, drop held items on flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_output actual=0x%0h required=none", a_out_data);
        end else begin
          chk("a_order", a_out_data, qa.pop_front());
        end
      end
      if (a_flush) qa.delete();
    end
  end

  // No-skid instance monitor: ordering plus the single-entry occupancy bound.
  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      chk("b_occ_le1", b_occ <= 2'd1, 1);
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_output actual=0x%0h required=none", b_out_data);
        end else begin
          chk("b_order", b_out_data, qb.pop_front());
        end
      end
      if (b_flush) qb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] stream [3];
    logic [1:0] sat_exp [4];
    stream  = '{8'h11, 8'h22, 8'h33};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_out_data", a_out_data, 8'hE5);
    chk("rst_kill", a_kill, 0);
    chk("rst_in_ready_a", a_in_ready, 1);
    chk("rst_in_ready_b", b_in_ready, 1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Streaming at full rate
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1;
      a_in_data  = stream[i];
      tick();
      chk("stream_data", a_out_data, stream[i]);
      chk("stream_in_ready", a_in_ready, 1);
      chk("stream_occ", a_occ, 1);
    end
    a_in_valid = 0;
    tick();
    chk("stream_drain_occ", a_occ, 0);

    // Back-pressure into the skid entry
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'hA1;
    tick();
    chk("bp_occ1", a_occ, 1);
    chk("bp_data1", a_out_data, 8'hA1);
    a_in_data = 8'hA2;
    tick();
    chk("bp_occ2", a_occ, 2);
    chk("bp_in_ready0", a_in_ready, 0);
    a_in_data = 8'hA3;
    tick();
    chk("bp_hold_occ", a_occ, 2);
    chk("bp_hold_data", a_out_data, 8'hA1);
    a_out_ready = 1;
    tick();
    chk("bp_rel_data2", a_out_data, 8'hA2);
    chk("bp_rel_occ", a_occ, 1);
    chk("bp_rel_in_ready", a_in_ready, 1);
    tick();
    chk("bp_rel_data3", a_out_data, 8'hA3);
    a_in_valid = 0;
    tick();
    chk("bp_drain_occ", a_occ, 0);

    // Flush while SKIDDED with downstream stalled
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'hB1;
    tick();
    a_in_data = 8'hB2;
    tick();
    chk("fl_pre_occ", a_occ, 2);
    a_in_data = 8'hB3; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_out_data", a_out_data, 8'hE5);
    chk("fl_occ", a_occ, 0);
    chk("fl_kill", a_kill, 2);
    chk("fl_in_ready", a_in_ready, 1);

    // Flush in a cycle where main fires and a new input is offered
    a_in_valid = 1; a_in_data = 8'hC1;
    tick();
    chk("ff_pre_occ", a_occ, 1);
    a_out_ready = 1; a_flush = 1; a_in_data = 8'h55;
    #1;
    chk("ff_visible_valid", a_out_valid, 1);
    chk("ff_visible_data", a_out_data, 8'hC1);
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("ff_kill", a_kill, 2);
    chk("ff_occ", a_occ, 0);
    repeat (3) tick();
    chk("ff_no_55", a_out_valid, 0);

    // Counter saturation with CNT_W=2
    rst = 1;
    #2;
    chk("sat_rst_kill", a_kill, 0);
    tick();
    rst = 0;
    tick();
    a_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1;
      a_in_data  = 8'hD0 + 8'(i);
      tick();
      a_in_valid = 0; a_flush = 1;
      tick();
      a_flush = 0;
      chk("sat_kill", a_kill, sat_exp[i]);
    end
    a_in_valid = 1; a_in_data = 8'hE0;
    tick();
    rst = 1;
    #2;
    chk("midrst_kill", a_kill, 0);
    chk("midrst_occ", a_occ, 0);
    chk("midrst_out_valid", a_out_valid, 0);
    a_in_valid = 0;
    tick();
    rst = 0;
    tick();

    // No-skid mode: combinational in_ready, single entry
    b_out_ready = 0;
    #1;
    chk("b_empty_in_ready", b_in_ready, 1);
    b_out_ready = 1; b_in_valid = 1; b_in_data = 8'h61;
    tick();
    chk("b_occ1", b_occ, 1);
    chk("b_data61", b_out_data, 8'h61);
    b_out_ready = 0; b_in_data = 8'h62;
    #1;
    chk("b_full_stall_in_ready", b_in_ready, 0);
    tick();
    chk("b_hold_data", b_out_data, 8'h61);
    chk("b_hold_occ", b_occ, 1);
    b_out_ready = 1;
    #1;
    chk("b_full_go_in_ready", b_in_ready, 1);
    tick();
    chk("b_data62", b_out_data, 8'h62);
    b_in_data = 8'h63;
    tick();
    chk("b_data63", b_out_data, 8'h63);
    b_in_valid = 0;
    tick();
    chk("b_drain_occ", b_occ, 0);
    chk("b_drain_valid", b_out_valid, 0);

    tick();
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
